mem_1r1w_init: RTL

MEM_1R1W_INIT -- requirements
Module: mem_1r1w_init

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_init_seq.sv | 66 ++++++
 rtl/mem_1r1w_init.sv | 88 ++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the 1R1W memory with power-up initialisation sweep.
// MEM_1R1W_BYPASS_EN selects new-data read-during-write behaviour.
package mem_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } mem_init_state_e;

`ifdef MEM_1R1W_BYPASS_EN
  localparam bit RDW_NEW_DATA = 1'b1;
`else
  localparam bit RDW_NEW_DATA = 1'b0;
`endif

endpackage

// File: rtl/mem_init_seq.sv
// Initialisation sequencer: sweeps every address once after reset, then
// holds READY. The memory array itself lives in the parent.
module mem_init_seq
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  output logic [ADDR_W-1:0] o_sweep_addr,
  output logic              o_sweep_we,
  output logic              o_init_done
);

  mem_init_state_e   r_state;
  mem_init_state_e   w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              w_we;
  logic              w_done;
  logic              w_last;

  assign w_last = (32'(r_cnt) == DEPTH - 1);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we        = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      INIT: begin
        w_we = 1'b1;
        if (w_last) begin
          w_state_nxt = READY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      READY: begin
        w_done = 1'b1;
      end
      default: begin
        w_state_nxt = INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Suppress the sweep write on a reset edge so reset never touches the array.
  assign o_sweep_we   = w_we & i_reset_n;
  assign o_sweep_addr = r_cnt;
  assign o_init_done  = w_done;

endmodule

// File: rtl/mem_1r1w_init.sv
// One-read/one-write bit-masked memory with a post-reset INIT_VAL sweep.
// Define MEM_1R1W_BYPASS_EN for new-data same-address read-during-write.
module mem_1r1w_init
  import mem_pkg::*;
#(
  parameter int unsigned      WIDTH    = 1,
  parameter int unsigned      DEPTH    = 128,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int unsigned     ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              R0_en,
  input  logic [ADDR_W-1:0] R0_addr,
  output logic [WIDTH-1:0]  R0_data,
  output logic              R0_valid,
  input  logic              W0_en,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic [WIDTH-1:0]  W0_data,
  input  logic [WIDTH-1:0]  W0_mask,
  output logic              init_done
);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] w_sweep_addr;
  logic              w_sweep_we;
  logic              w_init_done;
  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_user_we;
  logic              w_rd_acc;
  logic [WIDTH-1:0]  w_wr_merged;
  logic [WIDTH-1:0]  w_rd_word;
  logic [WIDTH-1:0]  r_rd_data;
  logic              r_rd_valid;

  mem_init_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .i_clock      (clock),
    .i_reset_n    (reset_n),
    .o_sweep_addr (w_sweep_addr),
    .o_sweep_we   (w_sweep_we),
    .o_init_done  (w_init_done)
  );

  assign w_wr_in_range = (32'(W0_addr) < DEPTH);
  assign w_rd_in_range = (32'(R0_addr) < DEPTH);
  assign w_user_we     = reset_n & w_init_done & W0_en & w_wr_in_range;
  assign w_rd_acc      = w_init_done & R0_en;
  assign w_wr_merged   = (r_mem[W0_addr] & ~W0_mask) | (W0_data & W0_mask);

`ifdef MEM_1R1W_BYPASS_EN
  logic w_fwd_hit;
  assign w_fwd_hit = RDW_NEW_DATA && W0_en && (W0_addr == R0_addr);
  assign w_rd_word = !w_rd_in_range ? '0 :
                     (w_fwd_hit ? w_wr_merged : r_mem[R0_addr]);
`else
  assign w_rd_word = w_rd_in_range ? r_mem[R0_addr] : '0;
`endif

  // Sweep and user port are mutually exclusive: user writes need READY.
  always_ff @(posedge clock) begin
    if (w_sweep_we) begin
      r_mem[w_sweep_addr] <= INIT_VAL;
    end else if (w_user_we) begin
      r_mem[W0_addr] <= w_wr_merged;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  assign R0_data   = r_rd_data;
  assign R0_valid  = r_rd_valid;
  assign init_done = w_init_done;

endmodule
